// File: rtl/decodifica_hamming_pkg.sv
// Shared Hamming(15,11) constants, codeword layout and helpers for the encoder/decoder pair.
package decodifica_hamming_pkg;

   localparam int unsigned CW_W   = 15;
   localparam int unsigned DATA_W = 11;
   localparam int unsigned SYN_W  = 4;

   // Data bit positions inside the codeword (bit index i is Hamming position 15-i)
   localparam int unsigned D10_IDX = 12;
   localparam int unsigned D9_HI   = 10;
   localparam int unsigned D9_LO   = 8;
   localparam int unsigned D6_HI   = 6;

   // Parity-check masks: syndrome bit k is the XOR of the codeword bits selected by mask k
   localparam logic [SYN_W-1:0][CW_W-1:0] SYN_MASK = {
      15'h00FF,   // s[3]: bits 7..0
      15'h0F0F,   // s[2]: bits 11..8, 3..0
      15'h3333,   // s[1]: bits 13,12,9,8,5,4,1,0
      15'h5555    // s[0]: bits 14,12,...,0
   };

   // Stage A payload: received codeword and its syndrome
   typedef struct packed {
      logic [CW_W-1:0]  cw;
      logic [SYN_W-1:0] syn;
   } stage_a_t;

   // Stage B payload: corrected data with status
   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              corr;
      logic [SYN_W-1:0]  syn;
   } stage_b_t;

   // Syndrome value (Hamming position) to codeword bit index
   function automatic logic [SYN_W-1:0] syn_to_idx(input logic [SYN_W-1:0] s);
      return SYN_W'(CW_W) - s;
   endfunction

   // Pull d10..d0 out of a codeword
   function automatic logic [DATA_W-1:0] extrai_dados(input logic [CW_W-1:0] cw);
      return {cw[D10_IDX], cw[D9_HI:D9_LO], cw[D6_HI:0]};
   endfunction

endpackage

// File: rtl/sindrome_hamming.sv
// Combinational 15->4 Hamming syndrome.
module sindrome_hamming
   import decodifica_hamming_pkg::*;
(
   input  logic [CW_W-1:0]  cw,
   output logic [SYN_W-1:0] sindrome_c
);

   // Each syndrome bit is the parity of its check group
   always_comb begin
      sindrome_c = '0;
      for (int k = 0; k < int'(SYN_W); k++) begin
         sindrome_c[k] = ^(cw & SYN_MASK[k]);
      end
   end

endmodule

// File: rtl/decodifica_hamming.sv
// Two-stage pipelined Hamming(15,11) SEC decoder with valid/ready stream and saturating corrected-word counter.
module decodifica_hamming
   import decodifica_hamming_pkg::*;
#(
   parameter int unsigned CNT_W = 16
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CW_W-1:0]   entrada,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] saida,
   output logic              corrigido,
   output logic [SYN_W-1:0]  sindrome,
   output logic [CNT_W-1:0]  err_count,
   input  logic              clr_count
);

   logic             a_valid;
   logic             b_valid;
   stage_a_t         a_q;
   stage_b_t         b_q;
   logic [SYN_W-1:0] syn_c;
   logic             a_ready_c;
   logic             b_ready_c;
   logic [CW_W-1:0]  flip_c;
   logic [CW_W-1:0]  cw_fix_c;

   sindrome_hamming u_sindrome (
      .cw         (entrada),
      .sindrome_c (syn_c)
   );

   // Ready chain: a stage can take a word if it is empty or is emptying this cycle
   assign b_ready_c = !b_valid || out_ready;
   assign a_ready_c = !a_valid || b_ready_c;
   assign in_ready  = a_ready_c;

   // Single-bit correction of the stage A word
   always_comb begin
      flip_c = '0;
      if (a_q.syn != '0) begin
         flip_c = CW_W'(1) << syn_to_idx(a_q.syn);
      end
      cw_fix_c = a_q.cw ^ flip_c;
   end

   // Stage A: capture codeword and syndrome on input transfer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_valid <= 1'b0;
         a_q     <= '0;
      end else if (a_ready_c) begin
         a_valid <= in_valid;
         if (in_valid) begin
            a_q <= '{cw: entrada, syn: syn_c};
         end
      end
   end

   // Stage B: capture corrected data; holds while the consumer stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         b_valid <= 1'b0;
         b_q     <= '0;
      end else if (b_ready_c) begin
         b_valid <= a_valid;
         if (a_valid) begin
            b_q <= '{data: extrai_dados(cw_fix_c), corr: (a_q.syn != '0), syn: a_q.syn};
         end
      end
   end

   // Corrected-word counter: clear wins, otherwise saturating increment on corrected output transfer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_count <= '0;
      end else if (clr_count) begin
         err_count <= '0;
      end else if (b_valid && out_ready && b_q.corr && (err_count != {CNT_W{1'b1}})) begin
         err_count <= err_count + CNT_W'(1);
      end
   end

   assign out_valid = b_valid;
   assign saida     = b_q.data;
   assign corrigido = b_q.corr;
   assign sindrome  = b_q.syn;

endmodule

// File: tb/tb_decodifica_hamming.sv
// Self-checking bench for decodifica_hamming: directed table, backpressure, random, exhaustive sweep, counter and reset.
module tb_decodifica_hamming;

   typedef struct packed {
      logic [14:0] cw;
      logic [10:0] data;
      logic        corr;
      logic [3:0]  syn;
   } vec_t;

   typedef struct packed {
      logic [10:0] data;
      logic        corr;
      logic [3:0]  syn;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [14:0] entrada = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [10:0] saida;
   logic        corrigido;
   logic [3:0]  sindrome;
   logic [15:0] err_count;
   logic        clr_count = 1'b0;

   logic        in_valid2 = 1'b0;
   logic        in_ready2;
   logic [14:0] entrada2 = '0;
   logic        out_valid2;
   logic        out_ready2 = 1'b1;
   logic [10:0] saida2;
   logic        corrigido2;
   logic [3:0]  sindrome2;
   logic [1:0]  err_count2;
   logic        clr_count2 = 1'b0;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   exp_t        exp_q[$];
   logic [15:0] exp_cnt = '0;
   logic        stall_prev = 1'b0;
   exp_t        held;

   decodifica_hamming dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .entrada(entrada),
      .out_valid(out_valid), .out_ready(out_ready), .saida(saida), .corrigido(corrigido),
      .sindrome(sindrome), .err_count(err_count), .clr_count(clr_count)
   );

   decodifica_hamming #(.CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .entrada(entrada2),
      .out_valid(out_valid2), .out_ready(out_ready2), .saida(saida2), .corrigido(corrigido2),
      .sindrome(sindrome2), .err_count(err_count2), .clr_count(clr_count2)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #5_000_000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   // Reference: syndrome is the XOR of the positions of all set bits; flip that position; data in ascending non-power-of-2 positions
   function automatic exp_t model(input logic [14:0] cw);
      int          s = 0;
      int          k = 10;
      logic [14:0] c = cw;
      exp_t        r = '0;
      for (int p = 1; p <= 15; p++) if (c[15-p]) s = s ^ p;
      if (s != 0) c[15-s] = ~c[15-s];
      for (int p = 1; p <= 15; p++) begin
         if ((p & (p - 1)) != 0) begin
            r.data[k] = c[15-p];
            k--;
         end
      end
      r.corr = (s != 0);
      r.syn  = 4'(s);
      return r;
   endfunction

   function automatic logic [14:0] enc(input logic [10:0] d);
      logic [14:0] c = '0;
      int          k = 10;
      int          s = 0;
      for (int p = 1; p <= 15; p++) begin
         if ((p & (p - 1)) != 0) begin
            c[15-p] = d[k];
            if (d[k]) s = s ^ p;
            k--;
         end
      end
      for (int b = 0; b < 4; b++) if (s[b]) c[15-(1<<b)] = 1'b1;
      return c;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [14:0] cw);
      int n = 0;
      in_valid = 1'b1;
      entrada  = cw;
      #1;
      while (!in_ready && n < 64) begin
         step();
         n++;
      end
      if (n >= 64) chk("push_timeout", 32'(in_ready), 1);
      step();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 100) begin
         step();
         n++;
      end
      if (n >= 100) chk("drain_timeout", 32'(exp_q.size()), 0);
   endtask

   // Scoreboard: decide at the falling edge what the next rising edge will transfer
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         exp_cnt    = '0;
         stall_prev = 1'b0;
      end else begin
         chk("err_count", 32'(err_count), 32'(exp_cnt));
         if (stall_prev) chk("stall_hold", {15'd0, out_valid, saida, corrigido, sindrome}, {15'd0, 1'b1, held});
         stall_prev = out_valid && !out_ready;
         held       = {saida, corrigido, sindrome};
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_out", 32'(out_valid), 0);
               if (clr_count) exp_cnt = '0;
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("out_word", 32'({saida, corrigido, sindrome}), 32'(e));
               if (clr_count) exp_cnt = '0;
               else if (e.corr && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
            end
         end else if (clr_count) begin
            exp_cnt = '0;
         end
         if (in_valid && in_ready) exp_q.push_back(model(entrada));
      end
   end

   initial begin
      vec_t        tbl[5];
      logic [14:0] w[5];
      int          c0;

      tbl[0] = '{cw: 15'h7FFF, data: 11'h7FF, corr: 1'b0, syn: 4'h0};
      tbl[1] = '{cw: 15'h7FFE, data: 11'h7FF, corr: 1'b1, syn: 4'hF};
      tbl[2] = '{cw: 15'h3FFF, data: 11'h7FF, corr: 1'b1, syn: 4'h1};
      tbl[3] = '{cw: 15'h0040, data: 11'h000, corr: 1'b1, syn: 4'h9};
      tbl[4] = '{cw: 15'h0003, data: 11'h003, corr: 1'b1, syn: 4'h1};

      // Reset state
      #12;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_saida", 32'(saida), 0);
      chk("rst_corrigido", 32'(corrigido), 0);
      chk("rst_sindrome", 32'(sindrome), 0);
      chk("rst_err_count", 32'(err_count), 0);
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_out_valid2", 32'(out_valid2), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step();

      // Directed table, one word at a time, checking latency
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         entrada  = tbl[i].cw;
         step();
         in_valid = 1'b0;
         chk("lat_edge1", 32'(out_valid), 0);
         step();
         chk("lat_edge2", 32'(out_valid), 1);
         chk("tbl_saida", 32'(saida), 32'(tbl[i].data));
         chk("tbl_corrigido", 32'(corrigido), 32'(tbl[i].corr));
         chk("tbl_sindrome", 32'(sindrome), 32'(tbl[i].syn));
         step();
         chk("tbl_consumed", 32'(out_valid), 0);
      end
      chk("tbl_err_count", 32'(err_count), 4);

      // Backpressure: two words fill the pipe, then in_ready follows out_ready
      for (int i = 0; i < 5; i++) w[i] = enc(11'(i * 37 + 5)) ^ (15'(1) << i);
      out_ready = 1'b0;
      push(w[0]);
      push(w[1]);
      chk("bp_full_in_ready", 32'(in_ready), 0);
      step();
      step();
      chk("bp_stall_in_ready", 32'(in_ready), 0);
      chk("bp_stall_out_valid", 32'(out_valid), 1);
      out_ready = 1'b1;
      #1;
      chk("bp_follow_in_ready", 32'(in_ready), 1);
      push(w[2]);
      push(w[3]);
      push(w[4]);
      drain();

      // Random traffic with random stalls and clears
      for (int i = 0; i < 400; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         entrada   = 15'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         clr_count = ($urandom_range(0, 31) == 0);
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      clr_count = 1'b0;
      drain();

      // Exhaustive sweep at full rate
      clr_count = 1'b1;
      step();
      clr_count = 1'b0;
      chk("sweep_clr", 32'(err_count), 0);
      c0 = cyc;
      for (int d = 0; d < 2048; d++) begin
         for (int e = 0; e < 16; e++) begin
            push(enc(11'(d)) ^ ((e == 0) ? 15'd0 : (15'(1) << (e - 1))));
         end
      end
      chk("sweep_rate", 32'(cyc - c0), 32768);
      drain();
      chk("sweep_err_count", 32'(err_count), 30720);

      // Narrow counter saturates, then clear beats a simultaneous corrected transfer
      in_valid2 = 1'b1;
      entrada2  = 15'h3FFF;
      repeat (5) step();
      in_valid2 = 1'b0;
      repeat (3) step();
      chk("sat_err_count2", 32'(err_count2), 3);
      chk("sat_idle2", 32'(out_valid2), 0);
      in_valid2 = 1'b1;
      step();
      in_valid2 = 1'b0;
      step();
      chk("clr_pending2", 32'({out_valid2, corrigido2}), 3);
      clr_count2 = 1'b1;
      step();
      clr_count2 = 1'b0;
      chk("clr_err_count2", 32'(err_count2), 0);

      // Reset with two words in flight
      out_ready = 1'b0;
      push(enc(11'h155) ^ 15'h0100);
      push(enc(11'h2AA));
      chk("rst_pre_full", 32'(out_valid), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_async_out_valid", 32'(out_valid), 0);
      chk("rst_async_err_count", 32'(err_count), 0);
      chk("rst_async_in_ready", 32'(in_ready), 1);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("rst_no_emit", 32'(out_valid), 0);
      end
      push(enc(11'h07B));
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
